pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline-stage register that generalises the fixed single-entry IF/ID, ID/EX, EX/MEM and MEM/WB latches. It carries a DATA_W-bit stage payload through a DEPTH-entry skid buffer with valid/ready handshaking on both sides, a single-cycle flush for branch or jump squashing, and saturating stall and bubble counters for performance visibility. Instances sit between adjacent datapath stages in the pipelined processor. The upstream ready signal does not depend combinationally on the downstream ready signal.

## Interface
- DATA_W, 32: payload width in bits, packing control bits, instr, incPC, pc, rdat1, rdat2 and ALU output. Legal range 1 to 512.
- DEPTH, 2: number of buffer entries. Legal range 1 to 8. DEPTH=1 behaves as a plain stage latch with bubble-on-full.
- CNT_W, 16: width of the performance counters.
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  reset, asynchronous and active-low.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  buffer can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  squash all buffered entries and any payload accepted this cycle.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head entry.
- out_data  out  DATA_W  head payload. Reads as all zeros when out_valid=0.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready; saturates.
- bubble_cnt  out  CNT_W  cycles with out_ready && !out_valid; saturates.
- clr_cnt  in  1  synchronous clear of both counters.

## Operation
- Storage is a circular buffer of DEPTH entries with a read pointer rd_ptr, a write pointer wr_ptr and a count.
- Each pointer wraps from DEPTH-1 to 0. This must also work when DEPTH is not a power of 2.
- in_ready = (count < DEPTH). It is decoded from registered state only.
- out_valid = (count != 0).
- out_data = entry[rd_ptr] when out_valid=1, otherwise 0.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- On push: entry[wr_ptr] <= in_data and wr_ptr advances.
- On pop: rd_ptr advances.
- Count update: count += push − pop. Push and pop in the same cycle leave count unchanged, which is legal at any occupancy below DEPTH.
- When full (count == DEPTH): in_ready=0. A pop that cycle does not enable a same-cycle push; in_ready rises the following cycle.
- Flush has priority over everything else. Next state is rd_ptr=wr_ptr=count=0.
  - The in_data presented that cycle is discarded.
  - The head entry is not consumed: the downstream must ignore out_data in a flush cycle.
- Counter update order each cycle:
  1. clr_cnt.
  2. Otherwise, increment if the condition holds and the counter is below 2^CNT_W−1.
- Counters evaluate the pre-flush out_valid and out_ready.
- Counters are not cleared by flush.
- Entry storage is not reset; only the pointers, count and counters are.

## Timing
- Reset (nRST=0, asynchronous) sets:
  - count=0, rd_ptr=0, wr_ptr=0.
  - out_valid=0, out_data=0.
  - in_ready=1, occupancy=0.
  - stall_cnt=0, bubble_cnt=0.
- Reset mid-operation discards all entries immediately, with no clock edge required.
- Latency: a payload pushed at edge N is visible on out_valid/out_data after edge N, i.e. in cycle N+1. There is no combinational in_data-to-out_data path.
- Throughput: one payload per cycle sustained while out_ready=1.
- in_ready has no combinational dependence on out_ready, flush or in_valid.
- out_valid and out_data depend only on registered state.
- occupancy is registered count.

## Test plan
- Reset/idle:
  - Assert nRST=0 mid-stream with count=2 → out_valid=0, in_ready=1, occupancy=0 immediately.
  - Hold idle with out_ready=1 for 5 cycles → bubble_cnt=5.
- Streaming (DEPTH=2):
  - Push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 → out_data 0x11, 0x22, 0x33 on the cycles following each push.
  - occupancy stays at 1 and stall_cnt=0.
- Backpressure and wrap:
  - Hold out_ready=0 and push A, B → in_ready=0 after 2 pushes; stall_cnt increments by 1 per cycle.
  - Then raise out_ready → A then B drain in order. in_ready returns to 1 one cycle after the first pop.
  - Repeat 5 times to exercise pointer wrap. Repeat with DEPTH=3 to cover a non-power-of-2 wrap.
- Flush:
  - With count=2, assert flush together with in_valid=1 and in_data=0x99 → next cycle count=0, out_valid=0, and 0x99 never appears at the output.
- Counter saturation:
  - With CNT_W=4, stall for 20 cycles → stall_cnt holds at 15.
  - clr_cnt → 0 next cycle.
  - clr_cnt asserted during a stall cycle → counter = 0, not 1.
- Simultaneous push and pop at count=1 → count stays 1 and data order is preserved. Check against a scoreboard in a random valid/ready/flush test of 10k cycles.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a DEPTH-entry circular skid buffer, valid/ready on
// both sides, single-cycle flush and saturating stall/bubble counters.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             bubble_cnt,
  input  logic                         clr_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Explicit wrap compare so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) return '0;
    return p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic clr,
                                                input logic cond);
    if (clr) return '0;
    if (cond && (c != CNT_MAX)) return c + CNT_W'(1);
    return c;
  endfunction

  assign w_full    = (r_count == OCC_FULL);
  assign w_valid   = (r_count != '0);
  assign w_push    = in_valid && !w_full && !flush;
  assign w_pop     = w_valid && out_ready && !flush;

  assign in_ready   = !w_full;
  assign out_valid  = w_valid;
  assign out_data   = w_valid ? r_mem[r_rd_ptr] : '0;
  assign occupancy  = r_count;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      // Counters see the pre-flush handshake and survive a flush.
      r_stall_cnt  <= sat_step(r_stall_cnt, clr_cnt, w_valid && !out_ready);
      r_bubble_cnt <= sat_step(r_bubble_cnt, clr_cnt, out_ready && !w_valid);
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + OCC_W'(1);
          2'b01:   r_count <= r_count - OCC_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: two instances (DEPTH=2/CNT_W=4 and DEPTH=3/CNT_W=16) share
// stimulus; a queue scoreboard per instance predicts every output each cycle.
module tb_pipe_skid_reg;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        tb_iv = 1'b0;
  logic [31:0] tb_d = '0;
  logic        tb_fl = 1'b0;
  logic        tb_ordy = 1'b0;
  logic        tb_clr = 1'b0;

  logic        ir0, ov0, ir1, ov1;
  logic [31:0] od0, od1;
  logic [1:0]  occ0, occ1;
  logic [3:0]  st0, bb0;
  logic [15:0] st1, bb1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];
  int mst0 = 0, mbb0 = 0, mst1 = 0, mbb1 = 0;

  always #5 CLK = ~CLK;

  pipe_skid_reg #(.DATA_W(32), .DEPTH(2), .CNT_W(4)) u_d2 (
    .CLK(CLK), .nRST(nRST), .in_valid(tb_iv), .in_ready(ir0), .in_data(tb_d),
    .flush(tb_fl), .out_valid(ov0), .out_ready(tb_ordy), .out_data(od0),
    .occupancy(occ0), .stall_cnt(st0), .bubble_cnt(bb0), .clr_cnt(tb_clr)
  );

  pipe_skid_reg #(.DATA_W(32), .DEPTH(3), .CNT_W(16)) u_d3 (
    .CLK(CLK), .nRST(nRST), .in_valid(tb_iv), .in_ready(ir1), .in_data(tb_d),
    .flush(tb_fl), .out_valid(ov1), .out_ready(tb_ordy), .out_data(od1),
    .occupancy(occ1), .stall_cnt(st1), .bubble_cnt(bb1), .clr_cnt(tb_clr)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq0.delete(); mq1.delete();
    mst0 = 0; mbb0 = 0; mst1 = 0; mbb1 = 0;
  endtask

  task automatic check_all();
    check("d2 out_valid", 32'(ov0), 32'(mq0.size() != 0));
    check("d2 in_ready",  32'(ir0), 32'(mq0.size() < 2));
    check("d2 occupancy", 32'(occ0), 32'(mq0.size()));
    check("d2 out_data",  od0, (mq0.size() != 0) ? mq0[0] : 32'h0);
    check("d2 stall_cnt", 32'(st0), 32'(mst0));
    check("d2 bubble_cnt", 32'(bb0), 32'(mbb0));
    check("d3 out_valid", 32'(ov1), 32'(mq1.size() != 0));
    check("d3 in_ready",  32'(ir1), 32'(mq1.size() < 3));
    check("d3 occupancy", 32'(occ1), 32'(mq1.size()));
    check("d3 out_data",  od1, (mq1.size() != 0) ? mq1[0] : 32'h0);
    check("d3 stall_cnt", 32'(st1), 32'(mst1));
    check("d3 bubble_cnt", 32'(bb1), 32'(mbb1));
  endtask

  task automatic model_update();
    logic ov, ir, psh, pp;
    logic [31:0] tmp;
    ov = (mq0.size() != 0); ir = (mq0.size() < 2);
    psh = tb_iv && ir && !tb_fl; pp = ov && tb_ordy && !tb_fl;
    if (tb_clr) begin mst0 = 0; mbb0 = 0; end
    else begin
      if (ov && !tb_ordy && mst0 < 15) mst0++;
      if (tb_ordy && !ov && mbb0 < 15) mbb0++;
    end
    if (tb_fl) mq0.delete();
    else begin
      if (pp) tmp = mq0.pop_front();
      if (psh) mq0.push_back(tb_d);
    end
    ov = (mq1.size() != 0); ir = (mq1.size() < 3);
    psh = tb_iv && ir && !tb_fl; pp = ov && tb_ordy && !tb_fl;
    if (tb_clr) begin mst1 = 0; mbb1 = 0; end
    else begin
      if (ov && !tb_ordy && mst1 < 65535) mst1++;
      if (tb_ordy && !ov && mbb1 < 65535) mbb1++;
    end
    if (tb_fl) mq1.delete();
    else begin
      if (pp) tmp = mq1.pop_front();
      if (psh) mq1.push_back(tb_d);
    end
  endtask

  // Called at posedge+1; checks pre-edge outputs, then advances model across the edge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                     input logic fl, input logic clr);
    tb_iv = iv; tb_d = d; tb_ordy = ordy; tb_fl = fl; tb_clr = clr;
    #3;
    check_all();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1};
    tbl[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1};
    tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
    tbl[6]  = '{1'b1, 32'hC3, 1'b1, 1'b0, 1'b1, 32'hB2, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h44, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h44, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};

    model_clear();
    @(posedge CLK); @(posedge CLK); #1;
    check("reset out_valid", 32'(ov0), 32'h0);
    check("reset in_ready", 32'(ir0), 32'h1);
    check("reset occupancy", 32'(occ0), 32'h0);
    check("reset out_data", od0, 32'h0);
    check("reset stall_cnt", 32'(st0), 32'h0);
    check("reset bubble_cnt", 32'(bb0), 32'h0);
    nRST = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, 1'b0);
      check($sformatf("vec%0d out_valid", i), 32'(ov0), 32'(tbl[i].ov));
      check($sformatf("vec%0d out_data", i), od0, tbl[i].od);
      check($sformatf("vec%0d occupancy", i), 32'(occ0), 32'(tbl[i].occ));
      check($sformatf("vec%0d in_ready", i), 32'(ir0), 32'(tbl[i].ir));
    end

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("idle bubble_cnt d2", 32'(bb0), 32'd5);
    check("idle bubble_cnt d3", 32'(bb1), 32'd5);

    cyc(1'b1, 32'h5A, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("sat stall_cnt d2", 32'(st0), 32'd15);
    check("sat stall_cnt d3", 32'(st1), 32'd20);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("clr in stall d2", 32'(st0), 32'd0);
    check("clr in stall d3", 32'(st1), 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 5; r++) begin
      cyc(1'b1, 32'hA000 + 32'(r), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hB000 + 32'(r), 1'b0, 1'b0, 1'b0);
      check("wrap full in_ready", 32'(ir0), 32'h0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("wrap in_ready after pop", 32'(ir0), 32'h1);
      check("wrap second head", od0, 32'hB000 + 32'(r));
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    cyc(1'b1, 32'h61, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h62, 1'b0, 1'b0, 1'b0);
    #2 nRST = 1'b0;
    #1;
    check("async rst out_valid", 32'(ov0), 32'h0);
    check("async rst in_ready", 32'(ir0), 32'h1);
    check("async rst occupancy", 32'(occ0), 32'h0);
    check("async rst d3 occupancy", 32'(occ1), 32'h0);
    model_clear();
    check_all();
    @(posedge CLK); #1;
    nRST = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
